riscv_top: RTL and testbench
============================

RISCV_TOP -- requirements
Module: riscv_top

Interface
REQ-001 SHALL have parameter CPU_DIV, default 1, meaning clocks per instruction step.
REQ-002 SHALL have parameter SCAN_BITS, default 16, meaning the width of the display scan counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port go, input, 1 bit: resume-from-pause level, synchronized through 2 flops before use.
REQ-006 SHALL have port AN, output, 8 bits: active-low digit select; AN[0] is the rightmost digit.
REQ-007 SHALL have port SEG, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1.

Function
REQ-008 SHALL implement a single-cycle RV32I-subset core with 32x32 registers; x0 reads 0 and writes to it are ignored.
REQ-009 SHALL support these instructions: LUI, ADDI, ANDI, ORI, XORI, SLTI, ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, BEQ, BNE, BLT, JAL, JALR, LW, SW, ECALL.
REQ-010 SHALL execute any other encoding as a NOP (PC+4).
REQ-011 SHALL use signed compares for SLT, SLTI and BLT.
REQ-012 SHALL use shift amount [4:0] for SLL and SRL.
REQ-013 SHALL use 32-bit wrap-around arithmetic with no overflow trap.
REQ-014 SHALL fetch instructions from a 64-word ROM addressed by PC[7:2]; PC wraps modulo 256 bytes.
REQ-015 SHALL provide a 16-word data RAM addressed by addr[5:2]; RAM is zeroed at reset.
REQ-016 SHALL ignore the low 2 address bits on LW and SW.
REQ-017 SHALL hold this default ROM program; all other words are 0:
- w0 addi x10,x0,0x12
- w1 addi x11,x0,0x34
- w2 add x10,x10,x11
- w3 ecall
- w4 sub x10,x10,x11
- w5 addi x17,x0,10
- w6 ecall
- w7 jal x0,0
REQ-018 SHALL retire one instruction per CPU_DIV clocks while in RUN.
REQ-019 SHALL implement FSM states RUN, PAUSE and HALT.
REQ-020 SHALL, on ECALL with x17 != 10 in RUN: load DISP <= x10, set PC <= PC+4, enter PAUSE.
REQ-021 SHALL, on ECALL with x17 == 10 in RUN: load DISP <= x10, leave PC unchanged, enter HALT.
REQ-022 SHALL return from PAUSE to RUN on the first step slot where synchronized go == 1.
REQ-023 SHALL keep go == 1 from skipping an ECALL: the ECALL still enters PAUSE for at least one step slot.
REQ-024 SHALL hold HALT until reset; go is ignored in HALT.
REQ-025 SHALL keep register and RAM writes disabled in PAUSE and HALT.
REQ-026 SHALL run a free scan counter of SCAN_BITS bits on every clk.
REQ-027 SHALL take digit index d from the counter's top 3 bits; AN = ~(1<<d) and SEG shows hex DISP[4d+3:4d].
REQ-028 SHALL use these hex codes for digits 0..F:
- 0..7: C0 F9 A4 B0 99 92 82 F8
- 8..F: 80 90 88 83 C6 A1 86 8E
REQ-029 SHALL give the display output path no pipeline beyond the combinational decode of the counter.

Reset
REQ-030 SHALL, while rst == 0, asynchronously clear PC, registers, RAM, DISP, scan counter, go synchronizer and step divider, and force state RUN.
REQ-031 SHALL hold AN = 8'hFE and SEG = 8'hC0 during reset.
REQ-032 SHALL execute the first instruction, ROM w0, at the first step slot after rst rises.
REQ-033 SHALL restart the program from w0 with DISP = 0 when reset is asserted mid-run or in PAUSE/HALT.

Verification
REQ-034 SHALL pass: reset held -> AN = FE, SEG = C0, PC = 0, DISP = 0.
REQ-035 SHALL pass: release reset, go = 0, CPU_DIV = 1 -> after 4 clocks, state PAUSE, DISP = 0x00000046, PC = 0x10; PC stays constant for 1000 clocks.
REQ-036 SHALL pass: go = 1 from PAUSE -> after sync plus 3 steps, state HALT, DISP = 0x00000012, PC = 0x18; PC unchanged thereafter.
REQ-037 SHALL pass: SCAN_BITS = 4, DISP = 0x46 -> over 16 clocks, digit 0 (AN = FE) SEG = 82, digit 1 (AN = FD) SEG = 99, digits 2..7 SEG = C0.
REQ-038 SHALL pass: rst pulsed low while in HALT -> state RUN, DISP = 0, program reaches PAUSE again with DISP = 0x46.
REQ-039 SHALL pass: go held 1 from reset -> PAUSE still entered at w3 for at least one step slot, then DISP = 0x12 and HALT by the 8th step.

Source files
------------

// File: rtl/riscv_top.sv
// riscv_top: single-cycle RV32I-subset core with a fixed ROM program, a small
// data RAM, RUN/PAUSE/HALT control driven by ECALL and a synchronized go
// input, and an 8-digit multiplexed hex display of the DISP register.
module riscv_top #(
    parameter int CPU_DIV   = 1,
    parameter int SCAN_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    output logic [7:0] AN,
    output logic [7:0] SEG
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PAUSE = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam int DW = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

    logic [1:0]           state, state_nxt;
    logic [7:0]           pc;
    logic [31:0]          disp;
    logic [31:0]          regs [32];
    logic [31:0]          ram  [16];
    logic [1:0]           go_sync;
    logic                 go_s;
    logic [DW-1:0]        div_cnt;
    logic                 step;
    logic                 commit;
    logic [SCAN_BITS-1:0] scan_cnt;

    // decode / execute wires
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1v, rs2v;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] mem_addr, jalr_t;
    logic [7:0]  pc_plus4;
    logic [7:0]  pc_next;
    logic [31:0] rd_val;
    logic        rd_we, mem_we, is_ecall;
    logic        unused_bits;

    assign go_s     = go_sync[1];
    assign step     = (div_cnt == DW'(CPU_DIV - 1));
    assign commit   = step && (state == ST_RUN);

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign f7       = instr[31:25];
    assign rs1v     = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2v     = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'd0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign mem_addr = rs1v + ((opcode == 7'b0100011) ? imm_s : imm_i);
    assign jalr_t   = rs1v + imm_i;
    assign pc_plus4 = pc + 8'd4;

    // address bits the 256-byte PC space and 16-word RAM never look at
    assign unused_bits = ^{mem_addr[31:6], mem_addr[1:0], jalr_t[31:8], jalr_t[0],
                           imm_b[31:8], imm_j[31:8]};

    // program ROM, word-addressed by PC[7:2]; unlisted words are zero (NOP)
    always_comb begin
        case (pc[7:2])
            6'd0:    instr = 32'h01200513; // addi x10,x0,0x12
            6'd1:    instr = 32'h03400593; // addi x11,x0,0x34
            6'd2:    instr = 32'h00B50533; // add  x10,x10,x11
            6'd3:    instr = 32'h00000073; // ecall
            6'd4:    instr = 32'h40B50533; // sub  x10,x10,x11
            6'd5:    instr = 32'h00A00893; // addi x17,x0,10
            6'd6:    instr = 32'h00000073; // ecall
            6'd7:    instr = 32'h0000006F; // jal  x0,0
            default: instr = 32'h00000000;
        endcase
    end

    // instruction decode and execute; unsupported encodings fall through as NOP
    always_comb begin
        rd_we    = 1'b0;
        rd_val   = 32'd0;
        pc_next  = pc_plus4;
        mem_we   = 1'b0;
        is_ecall = 1'b0;
        case (opcode)
            7'b0110111: begin rd_we = 1'b1; rd_val = imm_u; end
            7'b0010011: begin
                rd_we = 1'b1;
                case (f3)
                    3'b000:  rd_val = rs1v + imm_i;
                    3'b111:  rd_val = rs1v & imm_i;
                    3'b110:  rd_val = rs1v | imm_i;
                    3'b100:  rd_val = rs1v ^ imm_i;
                    3'b010:  rd_val = {31'd0, $signed(rs1v) < $signed(imm_i)};
                    default: rd_we  = 1'b0;
                endcase
            end
            7'b0110011: begin
                rd_we = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  rd_val = rs1v + rs2v;
                        3'b111:  rd_val = rs1v & rs2v;
                        3'b110:  rd_val = rs1v | rs2v;
                        3'b100:  rd_val = rs1v ^ rs2v;
                        3'b010:  rd_val = {31'd0, $signed(rs1v) < $signed(rs2v)};
                        3'b001:  rd_val = rs1v << rs2v[4:0];
                        3'b101:  rd_val = rs1v >> rs2v[4:0];
                        default: rd_we  = 1'b0;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    rd_val = rs1v - rs2v;
                end else begin
                    rd_we = 1'b0;
                end
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  if (rs1v == rs2v) pc_next = pc + imm_b[7:0];
                    3'b001:  if (rs1v != rs2v) pc_next = pc + imm_b[7:0];
                    3'b100:  if ($signed(rs1v) < $signed(rs2v)) pc_next = pc + imm_b[7:0];
                    default: pc_next = pc_plus4;
                endcase
            end
            7'b1101111: begin
                rd_we   = 1'b1;
                rd_val  = {24'd0, pc_plus4};
                pc_next = pc + imm_j[7:0];
            end
            7'b1100111: if (f3 == 3'b000) begin
                rd_we   = 1'b1;
                rd_val  = {24'd0, pc_plus4};
                pc_next = {jalr_t[7:1], 1'b0};
            end
            7'b0000011: if (f3 == 3'b010) begin
                rd_we  = 1'b1;
                rd_val = ram[mem_addr[5:2]];
            end
            7'b0100011: if (f3 == 3'b010) mem_we = 1'b1;
            7'b1110011: if (instr == 32'h00000073) is_ecall = 1'b1;
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_nxt;
    end

    // FSM next state: ECALL pauses or halts; go only resumes from PAUSE on a step
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (step && is_ecall) state_nxt = (regs[17] == 32'd10) ? ST_HALT : ST_PAUSE;
            ST_PAUSE: if (step && go_s) state_nxt = ST_RUN;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // display scan output: digit from counter top bits, hex nibble of DISP
    always_comb begin
        logic [2:0] d;
        logic [3:0] nib;
        d   = scan_cnt[SCAN_BITS-1 -: 3];
        nib = disp[{d, 2'b00} +: 4];
        AN  = ~(8'b1 << d);
        case (nib)
            4'h0: SEG = 8'hC0; 4'h1: SEG = 8'hF9; 4'h2: SEG = 8'hA4; 4'h3: SEG = 8'hB0;
            4'h4: SEG = 8'h99; 4'h5: SEG = 8'h92; 4'h6: SEG = 8'h82; 4'h7: SEG = 8'hF8;
            4'h8: SEG = 8'h80; 4'h9: SEG = 8'h90; 4'hA: SEG = 8'h88; 4'hB: SEG = 8'h83;
            4'hC: SEG = 8'hC6; 4'hD: SEG = 8'hA1; 4'hE: SEG = 8'h86; default: SEG = 8'h8E;
        endcase
    end

    // go synchronizer, step divider and free-running scan counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            go_sync  <= 2'b00;
            div_cnt  <= '0;
            scan_cnt <= '0;
        end else begin
            go_sync  <= {go_sync[0], go};
            div_cnt  <= step ? '0 : div_cnt + 1'b1;
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // PC and DISP commit; a halting ECALL leaves PC parked on itself
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc   <= 8'd0;
            disp <= 32'd0;
        end else if (commit) begin
            if (is_ecall) begin
                disp <= regs[10];
                pc   <= (regs[17] == 32'd10) ? pc : pc_plus4;
            end else begin
                pc <= pc_next;
            end
        end
    end

    // register file and data RAM writes, only while actually retiring in RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            for (int i = 0; i < 16; i++) ram[i]  <= 32'd0;
        end else if (commit) begin
            if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
            if (mem_we) ram[mem_addr[5:2]] <= rs2v;
        end
    end

endmodule

// File: tb/tb_riscv_top.sv
// tb_riscv_top: directed vector table plus randomized go/reset stimulus
// checked against an instruction-level model of the ROM program.
module tb_riscv_top;

    localparam logic [1:0] RUN = 2'd0, PAUSE = 2'd1, HALT = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go  = 1'b0;
    logic [7:0] AN, SEG;
    int         checks = 0;
    int         errors = 0;

    riscv_top #(.CPU_DIV(1), .SCAN_BITS(4)) dut (
        .clk(clk), .rst(rst), .go(go), .AN(AN), .SEG(SEG)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        go_v;
        int          clocks;
        logic [1:0]  st;
        logic [7:0]  pc;
        logic [31:0] disp;
    } vec_t;

    vec_t        vt [5];
    logic [7:0]  hex [16];
    logic [7:0]  dig_seg [8];

    // model state
    logic [1:0]  m_st;
    logic [7:0]  m_pc;
    logic [31:0] m_disp, m_x10, m_x11, m_x17;
    logic        m_g0, m_g1;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_core(input string name, input logic [1:0] st, input logic [7:0] pc,
                            input logic [31:0] disp);
        chk({name, ".state"}, {30'd0, dut.state}, {30'd0, st});
        chk({name, ".pc"},    {24'd0, dut.pc},    {24'd0, pc});
        chk({name, ".disp"},  dut.disp,           disp);
    endtask

    task automatic m_reset();
        m_st = RUN; m_pc = 0; m_disp = 0; m_x10 = 0; m_x11 = 0; m_x17 = 0;
        m_g0 = 0; m_g1 = 0; m_cnt = 0;
    endtask

    // one clock edge of the reference model
    task automatic m_clock(input logic r, input logic g);
        logic gs;
        if (!r) begin
            m_reset();
            return;
        end
        m_cnt = (m_cnt + 1) % 16;
        gs = m_g1; m_g1 = m_g0; m_g0 = g;
        case (m_st)
            RUN: begin
                case (m_pc / 4)
                    0: begin m_x10 = 32'h12; m_pc = m_pc + 4; end
                    1: begin m_x11 = 32'h34; m_pc = m_pc + 4; end
                    2: begin m_x10 = m_x10 + m_x11; m_pc = m_pc + 4; end
                    3, 6: begin
                        m_disp = m_x10;
                        if (m_x17 == 10) m_st = HALT;
                        else begin m_st = PAUSE; m_pc = m_pc + 4; end
                    end
                    4: begin m_x10 = m_x10 - m_x11; m_pc = m_pc + 4; end
                    5: begin m_x17 = 10; m_pc = m_pc + 4; end
                    7: ;
                    default: m_pc = m_pc + 4;
                endcase
            end
            PAUSE: if (gs) m_st = RUN;
            default: ;
        endcase
    endtask

    initial begin
        int seen;
        int d;
        logic [7:0] an_exp;

        hex = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        dig_seg = '{8'h82, 8'h99, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

        vt[0] = '{1'b0,    4, PAUSE, 8'h10, 32'h46};
        vt[1] = '{1'b0, 1000, PAUSE, 8'h10, 32'h46};
        vt[2] = '{1'b1,   10, HALT,  8'h18, 32'h12};
        vt[3] = '{1'b0,   50, HALT,  8'h18, 32'h12};
        vt[4] = '{1'b1,   50, HALT,  8'h18, 32'h12};

        // reset held
        repeat (3) @(negedge clk);
        chk("rst.AN", {24'd0, AN}, 32'hFE);
        chk("rst.SEG", {24'd0, SEG}, 32'hC0);
        chk_core("rst", RUN, 8'h00, 32'h0);

        // directed program walk: pause at w3, resume, halt at w6
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            go = vt[i].go_v;
            repeat (vt[i].clocks) @(negedge clk);
            chk_core($sformatf("vec%0d", i), vt[i].st, vt[i].pc, vt[i].disp);
        end

        // reset pulse while halted: async clear, then PAUSE again with 0x46
        go = 1'b0;
        rst = 1'b0;
        #1;
        chk_core("halt_rst", RUN, 8'h00, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk_core("rerun", PAUSE, 8'h10, 32'h46);

        // display scan of 0x46 over 16 clocks
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            d = -1;
            for (int j = 0; j < 8; j++) if (AN == ~(8'b1 << j)) d = j;
            chk("scan.AN_onehot", {31'd0, d >= 0}, 32'd1);
            if (d >= 0) begin
                chk($sformatf("scan.SEG%0d", d), {24'd0, SEG}, {24'd0, dig_seg[d]});
                seen = seen | (1 << d);
            end
        end
        chk("scan.all_digits", seen, 32'hFF);

        // go held high from reset: ECALL at w3 still pauses
        go = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            if (s == 4) chk_core("gohold.s4", PAUSE, 8'h10, 32'h46);
        end
        chk_core("gohold.s8", HALT, 8'h18, 32'h12);

        // randomized go and reset activity against the program model
        rst = 1'b0;
        go  = 1'b0;
        @(negedge clk);
        m_reset();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 6) == 0) go = ~go;
            @(negedge clk);
            m_clock(rst, go);
            chk_core("rand", m_st, m_pc, m_disp);
            d = m_cnt / 2;
            an_exp = ~(8'b1 << d);
            chk("rand.AN", {24'd0, AN}, {24'd0, an_exp});
            chk("rand.SEG", {24'd0, SEG}, {24'd0, hex[m_disp[d*4 +: 4]]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
